// File: rtl/ds_operand_stage_pkg.sv
// ds_operand_stage_pkg: shared width defaults and stage state encoding for the operand stage.
package ds_operand_stage_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int NUM_FWD_DEF = 3;
  localparam int PAY_W_DEF   = 64;
  localparam int CNT_W_DEF   = 8;
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/ds_operand_stage_if.sv
// ds_operand_stage_if: upstream, forwarding, regfile and downstream signals of the operand stage.
interface ds_operand_stage_if import ds_operand_stage_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int PAY_W   = PAY_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  logic                      in_valid;
  logic                      in_ready;
  logic [REG_AW-1:0]         in_rs;
  logic [REG_AW-1:0]         in_rt;
  logic                      in_use_rs;
  logic                      in_use_rt;
  logic [PAY_W-1:0]          in_payload;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*REG_AW-1:0] fwd_dest;
  logic [NUM_FWD-1:0]        fwd_rdy;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [REG_AW-1:0]         rf_raddr1;
  logic [REG_AW-1:0]         rf_raddr2;
  logic [DATA_W-1:0]         rf_rdata1;
  logic [DATA_W-1:0]         rf_rdata2;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_rs_value;
  logic [DATA_W-1:0]         out_rt_value;
  logic [PAY_W-1:0]          out_payload;
  logic [CNT_W-1:0]          stall_cnt;
  modport master (
    output in_valid, in_rs, in_rt, in_use_rs, in_use_rt, in_payload,
    output fwd_valid, fwd_dest, fwd_rdy, fwd_data, rf_rdata1, rf_rdata2, flush, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_rs_value, out_rt_value, out_payload, stall_cnt
  );
  modport slave (
    input  in_valid, in_rs, in_rt, in_use_rs, in_use_rt, in_payload,
    input  fwd_valid, fwd_dest, fwd_rdy, fwd_data, rf_rdata1, rf_rdata2, flush, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_rs_value, out_rt_value, out_payload, stall_cnt
  );
endinterface

// File: rtl/ds_operand_stage_fwd_select.sv
// fwd_select: priority forwarding match and mux for one operand; lowest source index wins.
module fwd_select import ds_operand_stage_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic                      en,
  input  logic [REG_AW-1:0]         addr,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0]         rf_data,
  output logic                      resolved,
  output logic [DATA_W-1:0]         value
);
  logic              hit, rdy;
  logic [DATA_W-1:0] data;
  // Scan oldest to youngest so the youngest match overwrites; a pending youngest blocks older data.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (en && addr != '0 && fwd_valid[i] && fwd_dest[i*REG_AW +: REG_AW] == addr) begin
        hit  = 1'b1;
        rdy  = fwd_rdy[i];
        data = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end
  assign resolved = !en | !hit | rdy;
  assign value    = !en ? '0 : hit ? data : rf_data;
endmodule

// File: rtl/ds_operand_stage.sv
// ds_operand_stage: single-entry operand stage resolving rs/rt via forwarding or regfile, with interlock stall count.
module ds_operand_stage import ds_operand_stage_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int PAY_W   = PAY_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  ds_operand_stage_if.slave bus
);
  state_t            state;
  logic [REG_AW-1:0] rs, rt;
  logic              use_rs, use_rt, cap_rs, cap_rt;
  logic [DATA_W-1:0] lat_rs, lat_rt, sel_rs, sel_rt;
  logic [PAY_W-1:0]  payload;
  logic [CNT_W-1:0]  stall_cnt;
  logic              res_rs, res_rt, ok_rs, ok_rt, ready, xfer, accept;
  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_rs (
    .en(use_rs), .addr(rs), .fwd_valid(bus.fwd_valid), .fwd_dest(bus.fwd_dest),
    .fwd_rdy(bus.fwd_rdy), .fwd_data(bus.fwd_data), .rf_data(bus.rf_rdata1),
    .resolved(res_rs), .value(sel_rs)
  );
  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_rt (
    .en(use_rt), .addr(rt), .fwd_valid(bus.fwd_valid), .fwd_dest(bus.fwd_dest),
    .fwd_rdy(bus.fwd_rdy), .fwd_data(bus.fwd_data), .rf_data(bus.rf_rdata2),
    .resolved(res_rt), .value(sel_rt)
  );
  assign ok_rs            = cap_rs | res_rs;
  assign ok_rt            = cap_rt | res_rt;
  assign ready            = ok_rs & ok_rt;
  assign bus.out_valid    = (state != S_EMPTY) & ready & !bus.flush;
  assign xfer             = bus.out_valid & bus.out_ready;
  assign bus.in_ready     = !bus.flush & ((state == S_EMPTY) | xfer);
  assign accept           = bus.in_valid & bus.in_ready;
  assign bus.rf_raddr1    = rs;
  assign bus.rf_raddr2    = rt;
  assign bus.out_rs_value = cap_rs ? lat_rs : sel_rs;
  assign bus.out_rt_value = cap_rt ? lat_rt : sel_rt;
  assign bus.out_payload  = payload;
  assign bus.stall_cnt    = stall_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_EMPTY;
      rs        <= '0;
      rt        <= '0;
      use_rs    <= 1'b0;
      use_rt    <= 1'b0;
      cap_rs    <= 1'b0;
      cap_rt    <= 1'b0;
      lat_rs    <= '0;
      lat_rt    <= '0;
      payload   <= '0;
      stall_cnt <= '0;
    end else if (bus.flush) begin
      state  <= S_EMPTY;
      cap_rs <= 1'b0;
      cap_rt <= 1'b0;
    end else if (accept) begin
      state     <= S_WAIT;
      rs        <= bus.in_rs;
      rt        <= bus.in_rt;
      use_rs    <= bus.in_use_rs;
      use_rt    <= bus.in_use_rt;
      payload   <= bus.in_payload;
      cap_rs    <= 1'b0;
      cap_rt    <= 1'b0;
      stall_cnt <= '0;
    end else if (xfer) begin
      state <= S_EMPTY;
    end else if (state != S_EMPTY) begin
      if (!cap_rs && res_rs) begin
        cap_rs <= 1'b1;
        lat_rs <= sel_rs;
      end
      if (!cap_rt && res_rt) begin
        cap_rt <= 1'b1;
        lat_rt <= sel_rt;
      end
      // Staying while resolved can only mean out_ready is low, so park in HOLD.
      if (ready) state <= S_HOLD;
      else stall_cnt <= &stall_cnt ? stall_cnt : stall_cnt + 1'b1;
    end
  end
endmodule

// File: doc/ds_operand_stage.md
DS_OPERAND_STAGE -- requirements
Module: ds_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand width.
REQ-002 SHALL have parameter REG_AW, default 5: register address width.
REQ-003 SHALL have parameter NUM_FWD, default 3: number of forwarding sources; index 0 is the youngest (execute stage).
REQ-004 SHALL have parameter PAY_W, default 64: opaque decoded payload width.
REQ-005 SHALL have parameter CNT_W, default 8: stall counter width.
REQ-006 SHALL have the clock and reset ports as follows: reset reset, synchronous, active-high; clock clk.
REQ-007 SHALL have ports:
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_rs, in_rt  in  REG_AW  source register numbers
- in_use_rs, in_use_rt  in  1  source actually read
- in_payload  in  PAY_W  decoded fields, passed through
- fwd_valid  in  NUM_FWD  source holds a register-writing instruction
- fwd_dest  in  NUM_FWD*REG_AW  destination per source
- fwd_rdy  in  NUM_FWD  result available this cycle (0 = load/multicycle pending)
- fwd_data  in  NUM_FWD*DATA_W  result per source
- rf_raddr1, rf_raddr2  out  REG_AW  regfile read addresses
- rf_rdata1, rf_rdata2  in  DATA_W  combinational regfile data
- flush  in  1  kill held instruction
- out_valid  out  1  instruction with resolved operands
- out_ready  in  1  downstream allowin
- out_rs_value, out_rt_value  out  DATA_W  operands
- out_payload  out  PAY_W  registered payload
- stall_cnt  out  CNT_W  interlock cycles of the current instruction

Function
REQ-010 SHALL hold at most one instruction; states EMPTY, WAIT (some operand unresolved), HOLD (operands resolved, out_ready low).
REQ-011 in_ready SHALL equal (state==EMPTY) | (out_valid & out_ready), and SHALL be forced to 0 when flush=1.
REQ-012 On in_valid & in_ready, SHALL register rs, rt, use flags and payload, clear both capture flags, and clear stall_cnt.
REQ-013 rf_raddr1/rf_raddr2 SHALL be the registered rs/rt.
REQ-014 An operand SHALL match source i iff its use flag is set, its register is nonzero, fwd_valid[i]=1, and fwd_dest[i] equals the register.
REQ-015 Among matching sources, the lowest index SHALL win.
REQ-016 An operand SHALL be resolved when it is captured, unused, unmatched (use regfile data), or its winning source has fwd_rdy=1 (use that fwd_data).
REQ-017 If the winning source has fwd_rdy=0, the operand SHALL be unresolved, even when an older source also matches.
REQ-018 Each cycle an uncaptured operand resolves while the instruction is not leaving, its value SHALL be latched and its capture flag set; later forwarding changes SHALL NOT alter it.
REQ-019 out_rs_value/out_rt_value SHALL be the latched value if captured, else the live resolved value; an unused operand SHALL read as 0.
REQ-020 out_valid SHALL be 1 iff state!=EMPTY and both operands are resolved; there SHALL be zero added latency from resolution to out_valid.
REQ-021 Transfer SHALL occur on out_valid & out_ready; the state SHALL go to EMPTY, or reload if in_valid is high the same cycle.
REQ-022 Transitions SHALL be:
- EMPTY->WAIT/HOLD on accept
- WAIT->HOLD when resolved & !out_ready
- HOLD->WAIT never
REQ-023 stall_cnt SHALL increment each cycle in WAIT and saturate at 2^CNT_W-1.
REQ-024 When flush=1, the state SHALL go to EMPTY next cycle; flush SHALL take priority over transfer (out_valid forced 0) and no new accept SHALL occur.
REQ-025 Payload SHALL pass through unmodified.

Reset
REQ-030 On reset the stage SHALL enter state EMPTY with capture flags=0, stall_cnt=0, out_valid=0, in_ready=1.
REQ-031 out_payload, operand latches and rf_raddr SHALL be 0 after reset.
REQ-032 Reset mid-WAIT SHALL discard the instruction without transfer.

Structure
REQ-040 State encodings and default parameter values SHALL live in the shared package/header next to the existing bus-width defines.
REQ-041 One sub-module SHALL exist: fwd_select (priority match and mux for one operand), instantiated twice.

Verification
REQ-050 rs=5, fwd0 dest 5 rdy=1 data 0x11 -> out_rs_value=0x11 same cycle; stall_cnt=0.
REQ-051 rs=5, fwd0 dest 5 rdy=0 for 2 cycles, then rdy=1 data 0x22 -> out_valid low 2 cycles, then 0x22; stall_cnt=2.
REQ-052 rs=0 with every fwd dest 0 -> regfile value used and no stall.
REQ-053 fwd0 and fwd2 both dest 7: fwd0 data 0xA, fwd2 data 0xB -> 0xA; with fwd0 rdy=0 -> stall and fwd2 is not used.
REQ-054 Resolved 0x33, out_ready low 3 cycles while fwd_data changes -> 0x33 delivered; single transfer.
REQ-055 flush in WAIT with in_valid=1 -> no transfer, incoming not accepted, EMPTY next cycle; CNT_W=2 long stall -> stall_cnt holds 3.
